// File: rtl/logic_gates_chk_pkg.sv
// rtl/logic_gates_chk_pkg.sv - shared constants, state type and helpers for the logic-gate checker
package logic_gates_chk_pkg;

  // Result bit positions on res_in
  localparam int AND_B  = 6;
  localparam int OR_B   = 5;
  localparam int NOT_B  = 4;
  localparam int NAND_B = 3;
  localparam int NOR_B  = 2;
  localparam int XOR_B  = 1;
  localparam int XNOR_B = 0;

  localparam int RES_W   = 7;
  localparam int NUM_VEC = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Reference gate results for one input vector
  function automatic logic [RES_W-1:0] gate_expect(input logic a, input logic b);
    logic [RES_W-1:0] r;
    r         = '0;
    r[AND_B]  = a & b;
    r[OR_B]   = a | b;
    r[NOT_B]  = ~a;
    r[NAND_B] = ~(a & b);
    r[NOR_B]  = ~(a | b);
    r[XOR_B]  = a ^ b;
    r[XNOR_B] = ~(a ^ b);
    return r;
  endfunction

  // Number of set bits in a 7-bit mismatch mask
  function automatic logic [2:0] popcount7(input logic [RES_W-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < RES_W; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/logic_gates_expect.sv
// rtl/logic_gates_expect.sv - combinational expected-result generator for the gate unit
module logic_gates_expect
  import logic_gates_chk_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] expected
);

  assign expected = gate_expect(a, b);

endmodule

// File: rtl/logic_gates_checker.sv
// rtl/logic_gates_checker.sv - stimulus source and response checker for the two-input gate unit
module logic_gates_checker
  import logic_gates_chk_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [RES_W-1:0] res_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_vec_cnt,
  output logic [4:0]       err_bit_cnt,
  output logic [1:0]       first_fail_vec,
  output logic [RES_W-1:0] first_fail_mask
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t           state, state_next;
  logic [1:0]       idx;
  logic [3:0]       cnt;
  logic [RES_W-1:0] expected;
  logic [RES_W-1:0] mask;
  logic [2:0]       mask_pop;
  logic             accept;
  logic             sample;

  logic_gates_expect u_expect (
    .a        (a_out),
    .b        (b_out),
    .expected (expected)
  );

  // mask is only consumed on compare edges, so res_in is don't-care elsewhere
  assign mask     = expected ^ res_in;
  assign mask_pop = popcount7(mask);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus run-start and compare strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          sample = 1'b1;
          if (idx == 2'd3) state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Stimulus, wait counter and result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out           <= 1'b0;
      b_out           <= 1'b0;
      idx             <= '0;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_vec_cnt     <= '0;
      err_bit_cnt     <= '0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else if (accept) begin
      a_out           <= 1'b0;
      b_out           <= 1'b0;
      idx             <= '0;
      cnt             <= LAT;
      busy            <= 1'b1;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_vec_cnt     <= '0;
      err_bit_cnt     <= '0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else if (state == S_WAIT) begin
      if (!sample) begin
        cnt <= cnt - 4'd1;
      end else begin
        if (mask != '0) begin
          err_vec_cnt <= err_vec_cnt + 3'd1;
          err_bit_cnt <= err_bit_cnt + {2'b00, mask_pop};
          if (err_vec_cnt == 3'd0) begin
            first_fail_vec  <= {a_out, b_out};
            first_fail_mask <= mask;
          end
        end
        if (idx != 2'd3) begin
          // vector order 00,01,10,11 is simply the index value
          idx            <= idx + 2'd1;
          {a_out, b_out} <= idx + 2'd1;
          cnt            <= LAT;
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_vec_cnt == 3'd0) && (mask == '0);
        end
      end
    end
  end

endmodule
